// File: rtl/spi_rgb_rx.sv
// spi_rgb_rx: SPI mode-0 slave decoding 4-byte frames into RGB duties
// and a test-mode flag, with per-channel glitch-free PWM outputs.
//
// Ports:
//   clk, nrst          system clock, async active-low reset
//   spi_sck/cs_n/mosi  async SPI pins, oversampled in the clk domain
//   spi_miso           status byte {6'b0, test_mode, err} during byte 0
//   out_r/g/b          registered PWM bits for the LED driver
//   test_mode          registered test-mode flag
//   frame_ok/err       1-cycle pulses: frame committed / rejected

module spi_rgb_rx #(
  parameter int PWM_BITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic out_r,
  output logic out_g,
  output logic out_b,
  output logic test_mode,
  output logic frame_ok,
  output logic frame_err
);

  localparam logic [7:0] CMD_SET  = 8'h01;
  localparam logic [7:0] CMD_TEST = 8'h02;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    RECV,
    COMMIT,
    ERROR
  } state_t;

  // ---------------------------------------------------------------
  // Pin synchronisers and edge strobes
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;
  logic                   cs_prev_q;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;

  // cs_n chain resets low so a frame in progress across reset
  // is never mistaken for a fresh cs_n falling edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q[0]  <= spi_sck;
      cs_sync_q[0]   <= spi_cs_n;
      mosi_sync_q[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync_q[i]  <= sck_sync_q[i-1];
        cs_sync_q[i]   <= cs_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  state_t              state_q, state_d;
  logic [31:0]         shreg_q, shreg_d;
  logic [5:0]          bitcnt_q, bitcnt_d;
  logic [7:0]          stat_q, stat_d;
  logic [2:0]          txcnt_q, txcnt_d;
  logic [2:0]          txidx;
  logic                miso_q, miso_d;
  logic                err_q, err_d;
  logic                tm_q, tm_d;
  logic                ok_q, errp_q;
  logic [PWM_BITS-1:0] shr_q, shr_d;
  logic [PWM_BITS-1:0] shg_q, shg_d;
  logic [PWM_BITS-1:0] shb_q, shb_d;

  function automatic logic [PWM_BITS-1:0] to_duty(
    input logic [7:0] b
  );
    return PWM_BITS'(b) << (PWM_BITS - 8);
  endfunction

  function automatic logic cmd_valid(input logic [7:0] c);
    return (c == CMD_SET) || (c == CMD_TEST);
  endfunction

  assign txidx = txcnt_q - 3'd1;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    stat_d   = stat_q;
    txcnt_d  = txcnt_q;
    miso_d   = 1'b0;
    err_d    = err_q;
    tm_d     = tm_q;
    shr_d    = shr_q;
    shg_d    = shg_q;
    shb_d    = shb_q;

    unique case (state_q)
      WAIT_IDLE: begin
        if (cs_s) state_d = IDLE;
      end

      IDLE: begin
        if (cs_fall) begin
          state_d  = RECV;
          bitcnt_d = '0;
          stat_d   = {6'b0, tm_q, err_q};
          miso_d   = stat_d[7];
          txcnt_d  = 3'd7;
        end
      end

      RECV: begin
        miso_d = miso_q;
        if (sck_rise) begin
          shreg_d = {shreg_q[30:0], mosi_s};
          if (bitcnt_q != 6'd33)
            bitcnt_d = bitcnt_q + 6'd1;
        end
        // txcnt counts status bits still to send after bit 7
        if (sck_fall) begin
          if (txcnt_q != 3'd0) begin
            miso_d  = stat_q[txidx];
            txcnt_d = txidx;
          end else begin
            miso_d = 1'b0;
          end
        end
        // Evaluated on the post-shift values so a final sck
        // edge in the same cycle still counts.
        if (cs_rise) begin
          miso_d = 1'b0;
          if (bitcnt_d == 6'd32 && cmd_valid(shreg_d[31:24]))
            state_d = COMMIT;
          else
            state_d = ERROR;
        end
      end

      COMMIT: begin
        if (shreg_q[31:24] == CMD_SET) begin
          shr_d = to_duty(shreg_q[23:16]);
          shg_d = to_duty(shreg_q[15:8]);
          shb_d = to_duty(shreg_q[7:0]);
        end else begin
          tm_d = shreg_q[16];
        end
        err_d   = 1'b0;
        state_d = IDLE;
      end

      ERROR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= WAIT_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      stat_q   <= '0;
      txcnt_q  <= '0;
      miso_q   <= 1'b0;
      err_q    <= 1'b0;
      tm_q     <= 1'b0;
      ok_q     <= 1'b0;
      errp_q   <= 1'b0;
      shr_q    <= '0;
      shg_q    <= '0;
      shb_q    <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      stat_q   <= stat_d;
      txcnt_q  <= txcnt_d;
      miso_q   <= miso_d;
      err_q    <= err_d;
      tm_q     <= tm_d;
      ok_q     <= (state_q == COMMIT);
      errp_q   <= (state_q == ERROR);
      shr_q    <= shr_d;
      shg_q    <= shg_d;
      shb_q    <= shb_d;
    end
  end

  // ---------------------------------------------------------------
  // PWM: duties reload from shadows only on the wrap cycle
  // ---------------------------------------------------------------
  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] dr_q, dg_q, db_q;
  logic                pr_q, pg_q, pb_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
      dr_q  <= '0;
      dg_q  <= '0;
      db_q  <= '0;
      pr_q  <= 1'b0;
      pg_q  <= 1'b0;
      pb_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + PWM_BITS'(1);
      if (&cnt_q) begin
        dr_q <= shr_q;
        dg_q <= shg_q;
        db_q <= shb_q;
      end
      pr_q <= (cnt_q < dr_q);
      pg_q <= (cnt_q < dg_q);
      pb_q <= (cnt_q < db_q);
    end
  end

  assign spi_miso  = miso_q;
  assign out_r     = pr_q;
  assign out_g     = pg_q;
  assign out_b     = pb_q;
  assign test_mode = tm_q;
  assign frame_ok  = ok_q;
  assign frame_err = errp_q;

endmodule
